axil_gpio_ctrl: RTL and testbench

// - AXI-lite slave holding the tile's control/status registers; sits on the external-write interconnect's

---
 rtl/axil_gpio_pkg.sv | 35 +++
 rtl/axil_gpio_ctrl_if.sv | 33 +++
 rtl/axil_gpio_ctrl.sv | 141 ++++++++++++++
 tb/tb_axil_gpio_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_gpio_pkg.sv
// Shared constants for the tile GPIO/control register block: register map,
// AXI response codes and register bit positions.
package axil_gpio_pkg;

  localparam logic [3:0] CTRL_OFFSET    = 4'h0;
  localparam logic [3:0] STATUS_OFFSET  = 4'h4;
  localparam logic [3:0] SCRATCH_OFFSET = 4'h8;

  // Register select is addr[3:2]; the fourth slot is intentionally unmapped.
  typedef enum logic [1:0] {
    REG_CTRL     = CTRL_OFFSET[3:2],
    REG_STATUS   = STATUS_OFFSET[3:2],
    REG_SCRATCH  = SCRATCH_OFFSET[3:2],
    REG_UNMAPPED = 2'd3
  } reg_sel_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_RUN_BIT    = 0;
  localparam int STATUS_TRAP_BIT = 0;
  localparam int STATUS_RSTN_BIT = 1;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_gpio_ctrl_if.sv
// AXI-lite register-access bundle between the interconnect GPIO port and the
// tile control block.
interface axil_gpio_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_gpio_ctrl.sv
// Tile control/status registers behind AXI-lite: CTRL.RUN, sticky TRAP,
// SCRATCH, and a CPU reset that is held low for RST_HOLD cycles after RUN rises.
module axil_gpio_ctrl
  import axil_gpio_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int RST_HOLD   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  axil_gpio_ctrl_if.slave s_axil,
  input  logic            cpu_trap,
  output logic            cpu_resetn
);

  localparam logic [7:0] HOLD_LOAD = 8'(RST_HOLD);

  logic        aw_full, w_full;
  logic        aw_ready_q, w_ready_q, ar_ready_q;
  reg_sel_e    aw_sel;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        b_valid_q, r_valid_q;
  logic [1:0]  b_resp_q, r_resp_q;
  logic [31:0] r_data_q;

  logic        ctrl_run, trap;
  logic [31:0] scratch;
  logic [7:0]  hold_cnt;

  logic        aw_hs, w_hs, ar_hs, commit, trap_clr;
  logic        aw_full_nxt, w_full_nxt, r_valid_nxt;
  reg_sel_e    ar_sel;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;

  assign aw_hs  = s_axil.awvalid && aw_ready_q;
  assign w_hs   = s_axil.wvalid  && w_ready_q;
  assign ar_hs  = s_axil.arvalid && ar_ready_q;
  // A held response blocks the commit; the holders may still refill behind it.
  assign commit = aw_full && w_full && !b_valid_q;

  assign aw_full_nxt = aw_hs || (aw_full && !commit);
  assign w_full_nxt  = w_hs  || (w_full  && !commit);
  assign r_valid_nxt = ar_hs || (r_valid_q && !s_axil.rready);

  assign trap_clr = commit && (aw_sel == REG_STATUS) && w_strb[0] && w_data[STATUS_TRAP_BIT];
  assign ar_sel   = reg_sel_e'(s_axil.araddr[3:2]);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (ar_sel)
      REG_CTRL:    rd_data[CTRL_RUN_BIT] = ctrl_run;
      REG_STATUS: begin
        rd_data[STATUS_TRAP_BIT] = trap;
        rd_data[STATUS_RSTN_BIT] = cpu_resetn;
      end
      REG_SCRATCH: rd_data = scratch;
      default:     rd_resp = RESP_SLVERR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full    <= 1'b0;
      w_full     <= 1'b0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      ar_ready_q <= 1'b0;
      aw_sel     <= REG_CTRL;
      w_data     <= '0;
      w_strb     <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      r_valid_q  <= 1'b0;
      r_resp_q   <= RESP_OKAY;
      r_data_q   <= '0;
    end else begin
      aw_full    <= aw_full_nxt;
      w_full     <= w_full_nxt;
      aw_ready_q <= !aw_full_nxt;
      w_ready_q  <= !w_full_nxt;
      ar_ready_q <= !r_valid_nxt;
      r_valid_q  <= r_valid_nxt;
      if (aw_hs) aw_sel <= reg_sel_e'(s_axil.awaddr[3:2]);
      if (w_hs) begin
        w_data <= s_axil.wdata;
        w_strb <= s_axil.wstrb;
      end
      if (ar_hs) begin
        r_data_q <= rd_data;
        r_resp_q <= rd_resp;
      end
      if (commit) begin
        b_valid_q <= 1'b1;
        b_resp_q  <= (aw_sel == REG_UNMAPPED) ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axil.bready) begin
        b_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_run   <= 1'b0;
      scratch    <= '0;
      trap       <= 1'b0;
      hold_cnt   <= '0;
      cpu_resetn <= 1'b0;
    end else begin
      if (commit && (aw_sel == REG_CTRL) && w_strb[0]) ctrl_run <= w_data[CTRL_RUN_BIT];
      if (commit && (aw_sel == REG_SCRATCH)) scratch <= apply_wstrb(scratch, w_data, w_strb);
      // Set wins over a same-cycle W1C so a trap is never lost.
      trap <= (trap && !trap_clr) || (cpu_trap && cpu_resetn);
      if (!ctrl_run) begin
        hold_cnt   <= HOLD_LOAD;
        cpu_resetn <= 1'b0;
      end else begin
        if (hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
        cpu_resetn <= (hold_cnt == 8'd0);
      end
    end
  end

  assign s_axil.awready = aw_ready_q;
  assign s_axil.wready  = w_ready_q;
  assign s_axil.arready = ar_ready_q;
  assign s_axil.bvalid  = b_valid_q;
  assign s_axil.bresp   = b_resp_q;
  assign s_axil.rvalid  = r_valid_q;
  assign s_axil.rresp   = r_resp_q;
  assign s_axil.rdata   = r_data_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axil.awaddr[ADDR_WIDTH-1:4], s_axil.awaddr[1:0],
                              s_axil.araddr[ADDR_WIDTH-1:4], s_axil.araddr[1:0]};

endmodule

// File: tb/tb_axil_gpio_ctrl.sv
// Scoreboard bench for axil_gpio_ctrl: expected responses are queued when a
// transaction is issued and compared when the DUT returns it.
module tb_axil_gpio_ctrl;
  import axil_gpio_pkg::*;

  localparam int AW       = 32;
  localparam int RST_HOLD = 16;
  localparam int TMO      = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_trap = 1'b0;
  logic cpu_resetn;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  b_q[$];
  logic [33:0] r_q[$];

  axil_gpio_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  axil_gpio_ctrl #(.ADDR_WIDTH(AW), .RST_HOLD(RST_HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_axil     (bus),
    .cpu_trap   (cpu_trap),
    .cpu_resetn (cpu_resetn)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no handshake within %0d cycles, expected one", name, TMO);
  endtask

  task automatic drive_aw(input logic [31:0] addr, input string name);
    int n = 0;
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    while (bus.awready !== 1'b1 && n < TMO) begin tick(); n++; end
    if (n == TMO) timeout_fail({name, " aw"});
    tick();
    bus.awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input string name);
    int n = 0;
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.wvalid = 1'b1;
    while (bus.wready !== 1'b1 && n < TMO) begin tick(); n++; end
    if (n == TMO) timeout_fail({name, " w"});
    tick();
    bus.wvalid = 1'b0;
  endtask

  task automatic collect_b(input string name);
    int n = 0;
    logic [1:0] exp;
    bus.bready = 1'b1;
    while (bus.bvalid !== 1'b1 && n < TMO) begin tick(); n++; end
    if (n == TMO || b_q.size() == 0) begin
      timeout_fail({name, " b"});
    end else begin
      exp = b_q.pop_front();
      n_tests++;
      if (bus.bresp !== exp) begin
        n_fail++;
        $display("FAIL %s bresp: got %b expected %b", name, bus.bresp, exp);
      end
    end
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] exp_resp, input bit w_first, input string name);
    b_q.push_back(exp_resp);
    if (w_first) begin
      drive_w(data, strb, name);
      drive_aw(addr, name);
    end else begin
      drive_aw(addr, name);
      drive_w(data, strb, name);
    end
    collect_b(name);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input string name);
    int n = 0;
    logic [33:0] exp;
    r_q.push_back({exp_resp, exp_data});
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    while (bus.arready !== 1'b1 && n < TMO) begin tick(); n++; end
    if (n == TMO) timeout_fail({name, " ar"});
    tick();
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    n = 0;
    while (bus.rvalid !== 1'b1 && n < TMO) begin tick(); n++; end
    if (n == TMO || r_q.size() == 0) begin
      timeout_fail({name, " r"});
    end else begin
      exp = r_q.pop_front();
      n_tests++;
      if ({bus.rresp, bus.rdata} !== exp) begin
        n_fail++;
        $display("FAIL %s read: got resp %b data %h expected resp %b data %h",
                 name, bus.rresp, bus.rdata, exp[33:32], exp[31:0]);
      end
    end
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic expect_rstn(input logic exp, input string name);
    n_tests++;
    if (cpu_resetn !== exp) begin
      n_fail++;
      $display("FAIL %s cpu_resetn: got %b expected %b", name, cpu_resetn, exp);
    end
  endtask

  task automatic idle_low(input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      tick();
      expect_rstn(1'b0, name);
    end
  endtask

  task automatic test_reset();
    logic [43:0] outs;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    bus.awaddr  = 32'h8;
    bus.awvalid = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    outs = {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
            bus.bresp, bus.rresp, bus.rdata, cpu_resetn};
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    tick(); tick();
    bus.awvalid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (bus.awready !== 1'b1 || bus.wready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got aw %b w %b expected 1 1", bus.awready, bus.wready);
    end
    // A lone W must not pair with the AW captured before reset.
    drive_w(32'h1234_5678, 4'hF, "reset_w");
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (bus.bvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_bvalid: got %b expected 0", bus.bvalid);
      end
      tick();
    end
    b_q.push_back(RESP_SLVERR);
    drive_aw(32'hC, "reset_drain");
    collect_b("reset_drain");
  endtask

  task automatic test_run_basic();
    logic [1:0] exp;
    b_q.push_back(RESP_OKAY);
    bus.awaddr  = 32'h0;
    bus.awvalid = 1'b1;
    n_tests++;
    if (bus.awready !== 1'b1) begin
      n_fail++;
      $display("FAIL run_awready: got %b expected 1", bus.awready);
    end
    tick();
    bus.awvalid = 1'b0;
    tick(); tick();
    bus.wdata  = 32'h0000_0001;
    bus.wstrb  = 4'hF;
    bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    n_tests++;
    if (bus.bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL run_bvalid_early: got %b expected 0", bus.bvalid);
    end
    bus.bready = 1'b1;
    tick();
    n_tests++;
    if (bus.bvalid !== 1'b1 || b_q.size() == 0) begin
      n_fail++;
      $display("FAIL run_bvalid: got %b expected 1", bus.bvalid);
    end else begin
      exp = b_q.pop_front();
      n_tests++;
      if (bus.bresp !== exp) begin
        n_fail++;
        $display("FAIL run_bresp: got %b expected %b", bus.bresp, exp);
      end
    end
    for (int i = 0; i < RST_HOLD; i++) begin
      tick();
      bus.bready = 1'b0;
    end
    expect_rstn(1'b0, "run_hold_last");
    tick();
    expect_rstn(1'b1, "run_release");
    do_read(32'h4, 32'h2, RESP_OKAY, "run_status");
  endtask

  task automatic test_scratch();
    do_write(32'h8, 32'hA5A5_A5A5, 4'hF, RESP_OKAY, 1'b0, "scr_full");
    do_write(32'h8, 32'hFFFF_FFFF, 4'h2, RESP_OKAY, 1'b0, "scr_byte1");
    do_read(32'h8, 32'hA5A5_FFA5, RESP_OKAY, "scr_aw_first");
    do_write(32'h8, 32'hA5A5_A5A5, 4'hF, RESP_OKAY, 1'b1, "scr_full_wf");
    do_write(32'h8, 32'hFFFF_FFFF, 4'h2, RESP_OKAY, 1'b1, "scr_byte1_wf");
    do_read(32'h8, 32'hA5A5_FFA5, RESP_OKAY, "scr_w_first");
    do_read(32'h0, 32'h1, RESP_OKAY, "ctrl_readback");
  endtask

  task automatic test_unmapped_backpressure();
    int n = 0;
    do_write(32'hC, 32'hDEAD_BEEF, 4'hF, RESP_SLVERR, 1'b0, "unmapped_wr");
    do_read(32'hC, 32'h0, RESP_SLVERR, "unmapped_rd");
    b_q.push_back(RESP_OKAY);
    b_q.push_back(RESP_OKAY);
    drive_aw(32'h8, "bp_first");
    drive_w(32'h1111_1111, 4'hF, "bp_first");
    while (bus.bvalid !== 1'b1 && n < TMO) begin tick(); n++; end
    if (n == TMO) timeout_fail("bp_first b");
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (bus.bvalid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold: got bvalid %b expected 1", bus.bvalid);
      end
    end
    drive_aw(32'h8, "bp_second");
    drive_w(32'h2222_2222, 4'hF, "bp_second");
    tick();
    n_tests++;
    if (bus.awready !== 1'b0 || bus.wready !== 1'b0 || bus.bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stall: got aw %b w %b b %b expected 0 0 1",
               bus.awready, bus.wready, bus.bvalid);
    end
    do_read(32'h8, 32'h1111_1111, RESP_OKAY, "bp_not_committed");
    collect_b("bp_first");
    collect_b("bp_second");
    do_read(32'h8, 32'h2222_2222, RESP_OKAY, "bp_committed");
  endtask

  task automatic test_trap();
    cpu_trap = 1'b1;
    tick();
    cpu_trap = 1'b0;
    do_read(32'h4, 32'h3, RESP_OKAY, "trap_set");
    cpu_trap = 1'b1;
    b_q.push_back(RESP_OKAY);
    drive_aw(32'h4, "trap_w1c_race");
    drive_w(32'h1, 4'h1, "trap_w1c_race");
    tick();
    cpu_trap = 1'b0;
    collect_b("trap_w1c_race");
    do_read(32'h4, 32'h3, RESP_OKAY, "trap_set_wins");
    do_write(32'h4, 32'h1, 4'h1, RESP_OKAY, 1'b0, "trap_w1c");
    do_read(32'h4, 32'h2, RESP_OKAY, "trap_cleared");
    do_write(32'h4, 32'hFFFF_FFFE, 4'hF, RESP_OKAY, 1'b1, "status_ro");
    do_read(32'h4, 32'h2, RESP_OKAY, "status_unchanged");
    do_write(32'h0, 32'h0, 4'hF, RESP_OKAY, 1'b0, "run_off");
    expect_rstn(1'b0, "run_off");
    cpu_trap = 1'b1;
    tick();
    cpu_trap = 1'b0;
    do_read(32'h4, 32'h0, RESP_OKAY, "trap_masked");
  endtask

  task automatic test_run_restart();
    do_write(32'h0, 32'h1, 4'h1, RESP_OKAY, 1'b0, "restart_on");
    idle_low(7, "restart_hold1");
    do_write(32'h0, 32'h0, 4'h1, RESP_OKAY, 1'b1, "restart_off");
    idle_low(3, "restart_off_hold");
    do_write(32'h0, 32'h1, 4'h1, RESP_OKAY, 1'b0, "restart_on2");
    idle_low(RST_HOLD - 1, "restart_hold2");
    tick();
    expect_rstn(1'b1, "restart_release");
  endtask

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    test_reset();
    test_run_basic();
    test_scratch();
    test_unmapped_backpressure();
    test_trap();
    test_run_restart();

    n_tests++;
    if (b_q.size() != 0 || r_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", b_q.size(), r_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
